cache_axi_rd_arbiter: RTL
=========================

// Module: cache_axi_rd_arbiter
// PURPOSE
//  Shares one AXI read channel (AR/R) between the cache-side read requesters: ICache refill, ICache uncached, DCache refill and DCache uncached.
//  - Grants one requester at a time and issues a single AXI burst.
//  - Collects the returned beats into a line buffer and hands the whole line (or the single word) back to the granted requester.
//  - Sits between the caches' rd_req/rd_rdy/ret_valid/ret_data handshakes and the top-level AXI master port.
// PARAMETERS
//  NUM_REQ        4   number of requesters; index 0 = highest fixed priority
//  LINE_WORD_NUM  4   words per cache line (burst length for line requests)
//  ID_WIDTH       4   AXI ID width; arid = granted index
// PORTS
//  clk            in   1                   clock
//  resetn         in   1                   synchronous, active-low reset
//  req_valid      in   NUM_REQ             rd_req per requester; held until req_rdy
//  req_addr       in   NUM_REQ*32          read address per requester, [32*i+:32]
//  req_line       in   NUM_REQ             1 = line burst, 0 = single word
//  req_rdy        out  NUM_REQ             one-cycle pulse: request accepted
//  ret_valid      out  NUM_REQ             one-cycle pulse: ret_data valid for requester i
//  ret_data       out  LINE_WORD_NUM*32    shared return bus; word k at [32*k+:32]
//  arid           out  ID_WIDTH            AXI AR channel ID
//  araddr         out  32                  AXI AR channel address
//  arlen          out  8                   AXI AR channel burst length
//  arsize         out  3                   AXI AR channel beat size
//  arburst        out  2                   AXI AR channel burst type
//  arvalid        out  1                   AXI AR channel valid
//  arready        in   1                   AXI AR channel ready
//  rid            in   ID_WIDTH            AXI R channel ID
//  rdata          in   32                  AXI R channel data
//  rresp          in   2                   AXI R channel response
//  rlast          in   1                   AXI R channel last beat
//  rvalid         in   1                   AXI R channel valid
//  rready         out  1                   AXI R channel ready
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; line buffer 0; beat counter 0; RR pointer 0.
//  States: IDLE -> AR -> R -> DONE -> IDLE.
//  IDLE:
//   - If any req_valid, register grant g, addr, line flag; go to AR.
//   - No req_valid: stay in IDLE.
//  AR:
//   - First cycle: req_rdy[g]=1 (single pulse).
//   - arvalid=1 and AR fields held stable until arready; on arvalid&arready go to R.
//  R:
//   - rready=1. Each rvalid beat writes rdata to buffer word[cnt]; cnt++.
//   - Go to DONE on rvalid&rlast.
//  DONE:
//   - ret_valid[g]=1 for exactly one cycle, ret_data=buffer; next state IDLE.
//   - New grant earliest in the following IDLE cycle (no back-to-back overlap).
//  AR fields:
//   - Line: araddr = addr with low log2(LINE_WORD_NUM*4) bits zeroed; arlen=LINE_WORD_NUM-1; arsize=3'b010; arburst=2'b01 (INCR).
//   - Single: araddr = addr unmodified; arlen=0; arsize=3'b010; arburst=2'b01; word lands in ret_data[31:0].
//  AXI R-channel handling:
//   - cnt is log2(LINE_WORD_NUM) bits and saturates at LINE_WORD_NUM-1: extra beats overwrite the last word, no wrap.
//   - rlast arriving early: DONE anyway, unwritten words keep their stale values.
//   - rid and rresp are ignored: there is no error path and no out-of-order support.
//  Requester behaviour:
//   - Dropping req_valid after grant does not abort; the transaction completes and ret_valid still pulses.
//   - Simultaneous requests: lowest index wins (fixed priority) unless RR is enabled.
//   - Requests for non-granted indices are never acknowledged until granted.
//   - ret_valid never pulses for a non-granted index.
//  Reset mid-operation: any state returns to IDLE next edge; arvalid/rready/ret_valid drop; in-flight beats discarded.
// CONFIGURATION
//  CACHE_ARB_RR_EN
//   - Defined: round-robin; search starts at (last grant+1) mod NUM_REQ; pointer updates on grant.
//   - Undefined: fixed priority, index 0 highest; no pointer register.
// TESTING
//  Line refill (fixed priority):
//   - Stimulus: req_valid[1], addr 0x1FC0_0014, line=1.
//   - Required: araddr 0x1FC0_0010, arlen=3, arid=1; beats A,B,C,D -> ret_valid[1] one cycle, ret_data={D,C,B,A}.
//  Uncached single:
//   - Stimulus: req 2, addr 0xBFAF_8004, line=0.
//   - Required: araddr 0xBFAF_8004, arlen=0; ret_data[31:0] = beat.
//  Contention (fixed priority):
//   - Stimulus: req 0 and 3 in the same cycle.
//   - Required: req 0 served first; req 3 granted in the IDLE after DONE.
//  Contention with CACHE_ARB_RR_EN:
//   - Stimulus: reqs 0,1 held continuously.
//   - Required: grants alternate 0,1,0,1.
//  Backpressure:
//   - Stimulus: arready low 5 cycles; rvalid gaps between beats.
//   - Required: AR fields stable while arvalid; data assembled correctly; single ret_valid pulse.
//  Reset during R:
//   - Stimulus: resetn=0 after beat 2.
//   - Required: next cycle all outputs 0, state IDLE; a new request then completes normally.

Source files
------------

// File: rtl/cache_axi_rd_arbiter.sv
// cache_axi_rd_arbiter: shares one AXI AR/R channel among cache read requesters.
// Define CACHE_ARB_RR_EN for round-robin grant; default is fixed priority.
module cache_axi_rd_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int LINE_WORD_NUM = 4,
  parameter int ID_WIDTH      = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_addr,
  input  logic [NUM_REQ-1:0]         req_line,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic [NUM_REQ-1:0]         ret_valid,
  output logic [LINE_WORD_NUM*32-1:0] ret_data,
  output logic [ID_WIDTH-1:0]        arid,
  output logic [31:0]                araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [ID_WIDTH-1:0]        rid,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LINE_WORD_NUM - 1);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORD_NUM * 4) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DONE
  } state_t;

  state_t state;
  logic [GW-1:0] gnt;
  logic [CW-1:0] cnt;
  logic [LINE_WORD_NUM*32-1:0] line_buf;
  logic [GW-1:0] pick;
  logic [31:0] pick_addr;

  logic unused_r;
  assign unused_r = ^{rid, rresp};

  assign ret_data  = line_buf;
  assign pick_addr = req_addr[32*pick +: 32];

`ifdef CACHE_ARB_RR_EN
  logic [GW-1:0] rr_ptr;
  int idx;

  // Descending scan so the requester nearest the pointer wins last.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) pick = GW'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (state == IDLE && |req_valid) begin
      rr_ptr <= (pick == GW'(NUM_REQ - 1)) ? '0 : pick + GW'(1);
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) pick = GW'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      gnt       <= '0;
      cnt       <= '0;
      line_buf  <= '0;
      req_rdy   <= '0;
      ret_valid <= '0;
      arid      <= '0;
      araddr    <= '0;
      arlen     <= '0;
      arsize    <= '0;
      arburst   <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
    end else begin
      req_rdy   <= '0;
      ret_valid <= '0;
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt     <= pick;
            req_rdy <= NUM_REQ'(1) << pick;
            arid    <= ID_WIDTH'(pick);
            araddr  <= req_line[pick] ? (pick_addr & LINE_MASK) : pick_addr;
            arlen   <= req_line[pick] ? 8'(LINE_WORD_NUM - 1) : 8'd0;
            arsize  <= 3'b010;
            arburst <= 2'b01;
            arvalid <= 1'b1;
            state   <= AR;
          end
        end
        AR: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            cnt     <= '0;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            line_buf[32*cnt +: 32] <= rdata;
            // Surplus beats keep landing in the last word.
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            if (rlast) begin
              rready    <= 1'b0;
              ret_valid <= NUM_REQ'(1) << gnt;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
